// File: rtl/word_serializer_if.sv
// Load-side handshake and serial-side outputs of word_serializer.
// master = word producer / serial consumer, slave = the serializer.
interface word_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             conv_reset;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, conv_reset, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, conv_reset, busy, done
    );
endinterface

// File: rtl/word_serializer.sv
// LSB-first parallel-to-serial converter with a converter-clear pulse before each word.
// Define SER_PREFETCH_EN to add a one-word holding buffer for back-to-back words.
module word_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    word_serializer_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             xfer;

`ifdef SER_PREFETCH_EN
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;

    assign bus.load_ready = !hold_full;
`else
    assign bus.load_ready = (state == IDLE);
`endif

    assign xfer = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
`ifdef SER_PREFETCH_EN
            hold      <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
`ifdef SER_PREFETCH_EN
            hold      <= hold_n;
            hold_full <= hold_full_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
`ifdef SER_PREFETCH_EN
        hold_n      = hold;
        hold_full_n = hold_full;
`endif
        unique case (state)
            IDLE: begin
`ifdef SER_PREFETCH_EN
                // A word buffered during the final DONE cycle starts from here.
                if (hold_full) begin
                    state_n     = CLR;
                    shreg_n     = hold;
                    hold_full_n = 1'b0;
                end else
`endif
                if (xfer) begin
                    state_n = CLR;
                    shreg_n = bus.load_data;
                end
            end
            CLR: begin
                state_n = SHIFT;
                cnt_n   = '0;
            end
            SHIFT: begin
                shreg_n = shreg >> 1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
`ifdef SER_PREFETCH_EN
                if (hold_full) begin
                    state_n     = CLR;
                    shreg_n     = hold;
                    hold_full_n = 1'b0;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
`ifdef SER_PREFETCH_EN
        // Ready implies an empty buffer, so this never collides with a drain above.
        if (xfer && state != IDLE) begin
            hold_n      = bus.load_data;
            hold_full_n = 1'b1;
        end
`endif
    end

    assign bus.ser_valid  = (state == SHIFT);
    assign bus.ser_out    = (state == SHIFT) && shreg[0];
    assign bus.conv_reset = (state == CLR);
    assign bus.done       = (state == DONE);
    assign bus.busy       = (state != IDLE);
endmodule
